life_scan_display: RTL and testbench
====================================

Name: life_scan_display

Overview:
- Double-buffered, self-timed LED-matrix scan driver for the life array.
- The generation engine streams a finished frame, one row word per transfer, into a back buffer.
- The scanner displays the front buffer one row at a time, with anti-ghost blanking and per-row PWM brightness.
- Back and front buffers swap only at frame boundaries, so a generation update never tears.

Parameters:
- X, 8, columns per row (width of col and wr_data)
- Y, 8, rows (width of row)
- LOG2X, 3, ceil(log2(X))
- LOG2Y, 3, ceil(log2(Y))
- DWELL, 16, active cycles per row (>=1)
- LOG2D, 4, ceil(log2(DWELL)); bright is LOG2D+1 bits
- BLANK, 2, blanking cycles before each row's active period (0 allowed)
- ROW_ACTIVE_LOW, 0, 1 = invert row outputs
- COL_ACTIVE_LOW, 0, 1 = invert col outputs

Ports:
- clk  in  1  system clock
- reset  in  1  async active-low reset
- wr_valid  in  1  row word offered
- wr_ready  out  1  back buffer can accept a row
- wr_data  in  X  row pixels, bit i = column i
- wr_last  in  1  last row of frame
- wr_err  out  1  one-cycle pulse on wr_last/row-index mismatch
- bright  in  LOG2D+1  lit cycles per row period
- frame_tick  out  1  one-cycle pulse at frame boundary
- scan_row  out  LOG2Y  row currently driven
- row  out  Y  one-hot row drive
- col  out  X  column drive

Behaviour:
- Reset:
  - Clock and reset: single clock clk; reset asynchronous, active-low.
  - On reset, clear both buffers, wr_ptr and complete.
  - row and col go to the inactive level: 0, or all-ones if the matching *_ACTIVE_LOW=1.
  - scan_row=0, wr_ready=1, wr_err=0, frame_tick=0.
  - Reset may assert at any time; state is abandoned immediately, with no partial swap.
- Write side:
  - A transfer occurs when wr_valid & wr_ready. It stores wr_data to back[wr_ptr] and increments wr_ptr.
  - The frame is complete when wr_last is accepted, or when wr_ptr=Y-1 is accepted. complete is set from that transfer.
  - While complete=1, wr_ready=0.
  - Early wr_last (wr_ptr<Y-1): pulse wr_err; rows above wr_ptr keep their old back-buffer contents.
  - Row Y-1 accepted without wr_last: pulse wr_err; the frame is still complete.
- Scan FSM:
  - States: BLNK (BLANK cycles, skipped if BLANK=0) then ACT (DWELL cycles). Then advance scan_row, wrapping Y-1 -> 0.
  - All outputs are registered.
  - Frame period is exactly Y*(BLANK+DWELL) cycles.
  - The first active output cycle of row 0 is cycle BLANK after reset release.
  - BLNK: row and col inactive.
  - ACT:
    - row = one-hot(scan_row), polarity applied.
    - col = front[scan_row] while act_cnt < bright_l, otherwise inactive.
    - bright_l is latched from bright on entry to ACT; mid-row changes of bright are ignored.
    - bright=0 gives a dark row; bright>=DWELL gives full on.
- Frame boundary (last ACT cycle of row Y-1):
  - frame_tick=1 in the cycle after it (aligned with the first cycle of the new frame).
  - If complete was 1 before this cycle's edge: front <= back, complete <= 0, wr_ptr <= 0, wr_ready=1 next cycle.
  - The new frame is displayed from row 0 onward.
  - A frame completed in the boundary cycle itself waits for the next boundary. No transfer can coincide with a swap, because wr_ready=0 whenever complete=1.
  - If complete=0, the front buffer is redisplayed unchanged.
- Widths: act_cnt is LOG2D+1 bits. Compare act_cnt < bright_l unsigned; no truncation of bright.

Test Plan (X=Y=8, DWELL=4, LOG2D=2, BLANK=1 unless noted):
1. Reset, then release:
   - row=0x00, col=0x00, wr_ready=1.
   - row=0x01 at cycle 1 for 4 cycles, row=0x02 at cycle 6.
   - frame_tick every 40 cycles.
2. Write rows 0x01,0x02,...,0x80 with wr_last on the 8th:
   - wr_ready=0 until the next frame_tick.
   - Next frame shows row 0x01 with col=0x01, and row 0x08 with col=0x08.
   - wr_err never pulses.
3. bright=2: col lit 2 of 4 ACT cycles per row. bright=0: col always 0x00. bright=7: lit 4/4. Changing bright mid-ACT takes effect only at the next row.
4. Write errors:
   - wr_last on the 3rd row: wr_err pulse; rows 3..7 keep old data after the swap.
   - 8 rows with no wr_last: wr_err pulse on the 8th; the swap still occurs.
5. Polarity and blanking:
   - COL_ACTIVE_LOW=1, ROW_ACTIVE_LOW=1: idle row=0xFF, col=0xFF; active row 2 gives row=0xFB and inverted data.
   - BLANK=0: rows are back-to-back and the frame period is 32 cycles.
6. Reset mid-frame during a write burst: outputs go inactive immediately. After release, scan restarts at row 0 and wr_ptr=0, and the front buffer is all zero.

Source files
------------

// File: rtl/life_scan_display_if.sv
// Write-side bundle between the life generation engine (master) and the
// scan display (slave): one row word per valid/ready transfer.
interface life_scan_display_if #(
  parameter int X = 8
) ();
  logic         wr_valid;
  logic         wr_ready;
  logic [X-1:0] wr_data;
  logic         wr_last;
  logic         wr_err;

  modport master (
    output wr_valid,
    output wr_data,
    output wr_last,
    input  wr_ready,
    input  wr_err
  );

  modport slave (
    input  wr_valid,
    input  wr_data,
    input  wr_last,
    output wr_ready,
    output wr_err
  );
endinterface

// File: rtl/life_scan_display.sv
// Double-buffered LED-matrix scan driver for the life array.
// Rows stream into a back buffer; the front buffer is scanned row by row
// (blanking, then DWELL active cycles with PWM on the columns). The buffers
// swap only at the frame boundary, so a displayed frame never tears.
module life_scan_display #(
  parameter int X              = 8,
  parameter int Y              = 8,
  parameter int LOG2X          = 3,
  parameter int LOG2Y          = 3,
  parameter int DWELL          = 16,
  parameter int LOG2D          = 4,
  parameter int BLANK          = 2,
  parameter int ROW_ACTIVE_LOW = 0,
  parameter int COL_ACTIVE_LOW = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  life_scan_display_if.slave        wr,
  input  logic [LOG2D:0]            bright,
  output logic                      frame_tick,
  output logic [LOG2Y-1:0]          scan_row,
  output logic [Y-1:0]              row,
  output logic [X-1:0]              col
);

  localparam int BW = (BLANK > 1) ? $clog2(BLANK) : 1;

  if ((X > (1 << LOG2X)) || (Y > (1 << LOG2Y)) || (DWELL > (1 << LOG2D))) begin : g_param_check
    $error("life_scan_display: LOG2X/LOG2Y/LOG2D too small for X/Y/DWELL");
  end

  typedef enum logic {
    S_BLNK,
    S_ACT
  } phase_e;

  phase_e           phase_q, phase_d;
  logic [BW-1:0]    blk_cnt_q, blk_cnt_d;
  logic [LOG2D:0]   act_cnt_q, act_cnt_d;
  logic [LOG2D:0]   bright_l_q, bright_l_d;
  logic [LOG2Y-1:0] scan_row_q, scan_row_d;
  logic             run_q, run_d;
  logic             boundary;

  logic [X-1:0]     back_q  [Y];
  logic [X-1:0]     back_d  [Y];
  logic [X-1:0]     front_q [Y];
  logic [X-1:0]     front_d [Y];
  logic [LOG2Y-1:0] wr_ptr_q, wr_ptr_d;
  logic             complete_q, complete_d;
  logic             err_q, err_d;
  logic             tick_q, tick_d;
  logic             xfer;
  logic             last_row;

  logic [Y-1:0]     row_raw_q, row_raw_d;
  logic [X-1:0]     col_raw_q, col_raw_d;

  // Scan position: blanking then active phase per row, rows wrap at Y-1.
  // run_q gives one lead-in cycle after reset so that the registered outputs,
  // computed from the next position, start with row 0's first phase.
  always_comb begin
    phase_d    = phase_q;
    blk_cnt_d  = blk_cnt_q;
    act_cnt_d  = act_cnt_q;
    bright_l_d = bright_l_q;
    scan_row_d = scan_row_q;
    run_d      = 1'b1;
    boundary   = 1'b0;
    if (!run_q) begin
      scan_row_d = '0;
      blk_cnt_d  = '0;
      act_cnt_d  = '0;
      if (BLANK == 0) begin
        phase_d    = S_ACT;
        bright_l_d = bright;
      end else begin
        phase_d = S_BLNK;
      end
    end else if (phase_q == S_BLNK) begin
      if (blk_cnt_q == BW'(BLANK - 1)) begin
        phase_d    = S_ACT;
        act_cnt_d  = '0;
        bright_l_d = bright;
      end else begin
        blk_cnt_d = blk_cnt_q + BW'(1);
      end
    end else begin
      if (act_cnt_q == (LOG2D + 1)'(DWELL - 1)) begin
        boundary   = (scan_row_q == LOG2Y'(Y - 1));
        scan_row_d = boundary ? '0 : scan_row_q + LOG2Y'(1);
        act_cnt_d  = '0;
        blk_cnt_d  = '0;
        if (BLANK == 0) begin
          phase_d    = S_ACT;
          bright_l_d = bright;
        end else begin
          phase_d = S_BLNK;
        end
      end else begin
        act_cnt_d = act_cnt_q + (LOG2D + 1)'(1);
      end
    end
  end

  // Back-buffer fill, completion/error tracking and swap at the frame boundary.
  always_comb begin
    back_d     = back_q;
    front_d    = front_q;
    wr_ptr_d   = wr_ptr_q;
    complete_d = complete_q;
    err_d      = 1'b0;
    tick_d     = boundary;
    xfer       = wr.wr_valid && !complete_q;
    last_row   = (wr_ptr_q == LOG2Y'(Y - 1));
    if (boundary && complete_q) begin
      front_d    = back_q;
      complete_d = 1'b0;
      wr_ptr_d   = '0;
    end else if (xfer) begin
      back_d[wr_ptr_q] = wr.wr_data;
      wr_ptr_d         = wr_ptr_q + LOG2Y'(1);
      err_d            = (wr.wr_last != last_row);
      if (wr.wr_last || last_row) begin
        complete_d = 1'b1;
      end
    end
  end

  // Drive levels for the next cycle, taken from the next scan position.
  always_comb begin
    row_raw_d = '0;
    col_raw_d = '0;
    if (phase_d == S_ACT) begin
      row_raw_d[scan_row_d] = 1'b1;
      if (act_cnt_d < bright_l_d) begin
        col_raw_d = front_d[scan_row_d];
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_q    <= S_BLNK;
      blk_cnt_q  <= '0;
      act_cnt_q  <= '0;
      bright_l_q <= '0;
      scan_row_q <= '0;
      run_q      <= 1'b0;
      wr_ptr_q   <= '0;
      complete_q <= 1'b0;
      err_q      <= 1'b0;
      tick_q     <= 1'b0;
      row_raw_q  <= '0;
      col_raw_q  <= '0;
      for (int unsigned i = 0; i < Y; i++) begin
        back_q[i]  <= '0;
        front_q[i] <= '0;
      end
    end else begin
      phase_q    <= phase_d;
      blk_cnt_q  <= blk_cnt_d;
      act_cnt_q  <= act_cnt_d;
      bright_l_q <= bright_l_d;
      scan_row_q <= scan_row_d;
      run_q      <= run_d;
      wr_ptr_q   <= wr_ptr_d;
      complete_q <= complete_d;
      err_q      <= err_d;
      tick_q     <= tick_d;
      row_raw_q  <= row_raw_d;
      col_raw_q  <= col_raw_d;
      back_q     <= back_d;
      front_q    <= front_d;
    end
  end

  assign row         = (ROW_ACTIVE_LOW != 0) ? ~row_raw_q : row_raw_q;
  assign col         = (COL_ACTIVE_LOW != 0) ? ~col_raw_q : col_raw_q;
  assign scan_row    = scan_row_q;
  assign frame_tick  = tick_q;
  assign wr.wr_ready = ~complete_q;
  assign wr.wr_err   = err_q;

endmodule

// File: tb/tb_life_scan_display.sv
// Bench for life_scan_display: three instances (active-high BLANK=1,
// active-low BLANK=1 sharing the same write stream, active-high BLANK=0
// idle) checked every cycle against a time-based reference model.
module tb_life_scan_display;
  localparam int FP0 = 40;  // Y*(BLANK+DWELL) with BLANK=1, DWELL=4
  localparam int FP2 = 32;  // Y*DWELL with BLANK=0

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic       wv, wl;
  logic [7:0] wd;
  logic [2:0] bright;

  logic       ft0, ft1, ft2;
  logic [2:0] sr0, sr1, sr2;
  logic [7:0] row0, row1, row2, col0, col1, col2;

  life_scan_display_if #(.X(8)) if0 ();
  life_scan_display_if #(.X(8)) if1 ();
  life_scan_display_if #(.X(8)) if2 ();

  assign if0.wr_valid = wv;
  assign if0.wr_data  = wd;
  assign if0.wr_last  = wl;
  assign if1.wr_valid = wv;
  assign if1.wr_data  = wd;
  assign if1.wr_last  = wl;
  assign if2.wr_valid = 1'b0;
  assign if2.wr_data  = 8'h00;
  assign if2.wr_last  = 1'b0;

  life_scan_display #(.X(8), .Y(8), .LOG2X(3), .LOG2Y(3), .DWELL(4), .LOG2D(2), .BLANK(1),
                      .ROW_ACTIVE_LOW(0), .COL_ACTIVE_LOW(0)) u0 (
    .clk(clk), .reset(reset), .wr(if0), .bright(bright),
    .frame_tick(ft0), .scan_row(sr0), .row(row0), .col(col0));

  life_scan_display #(.X(8), .Y(8), .LOG2X(3), .LOG2Y(3), .DWELL(4), .LOG2D(2), .BLANK(1),
                      .ROW_ACTIVE_LOW(1), .COL_ACTIVE_LOW(1)) u1 (
    .clk(clk), .reset(reset), .wr(if1), .bright(bright),
    .frame_tick(ft1), .scan_row(sr1), .row(row1), .col(col1));

  life_scan_display #(.X(8), .Y(8), .LOG2X(3), .LOG2Y(3), .DWELL(4), .LOG2D(2), .BLANK(0),
                      .ROW_ACTIVE_LOW(0), .COL_ACTIVE_LOW(0)) u2 (
    .clk(clk), .reset(reset), .wr(if2), .bright(bright),
    .frame_tick(ft2), .scan_row(sr2), .row(row2), .col(col2));

  // Reference model state (t = cycle index since reset release, -1 before).
  typedef struct {
    logic [7:0] d;
    bit         l;
  } wr_t;

  int         checks = 0;
  int         failures = 0;
  int         t;
  logic [7:0] front_m [8];
  logic [7:0] back_m  [8];
  bit         complete_m;
  int         ptr_m;
  bit         err_m, tick0_m, tick2_m;
  int         bl_m;
  int         ticks_obs;
  wr_t        wq[$];
  bit         rand_gaps, rand_bright;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h (t=%0d)", tag, obs, exp, t);
    end
  endtask

  task automatic model_reset();
    t = -1;
    for (int i = 0; i < 8; i++) begin
      front_m[i] = 8'h00;
      back_m[i]  = 8'h00;
    end
    complete_m = 1'b0;
    ptr_m      = 0;
    err_m      = 1'b0;
    tick0_m    = 1'b0;
    tick2_m    = 1'b0;
    bl_m       = 0;
    ticks_obs  = 0;
    wq.delete();
    wv = 1'b0;
    wl = 1'b0;
    wd = 8'h00;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_row0"}, 32'(row0), 32'h00);
    chk({tag, "_col0"}, 32'(col0), 32'h00);
    chk({tag, "_sr0"}, 32'(sr0), 32'h0);
    chk({tag, "_ready0"}, 32'(if0.wr_ready), 32'h1);
    chk({tag, "_err0"}, 32'(if0.wr_err), 32'h0);
    chk({tag, "_tick0"}, 32'(ft0), 32'h0);
    chk({tag, "_row1"}, 32'(row1), 32'hFF);
    chk({tag, "_col1"}, 32'(col1), 32'hFF);
    chk({tag, "_row2"}, 32'(row2), 32'h00);
    chk({tag, "_col2"}, 32'(col2), 32'h00);
  endtask

  // Advance the model across one clock edge, using the inputs as driven.
  task automatic model_edge();
    bit bnd0, bnd2;
    bnd0  = (t >= 0) && (t % FP0 == FP0 - 1);
    bnd2  = (t >= 0) && (t % FP2 == FP2 - 1);
    err_m = 1'b0;
    if (bnd0 && complete_m) begin
      front_m    = back_m;
      complete_m = 1'b0;
      ptr_m      = 0;
    end else if (wv && !complete_m) begin
      back_m[ptr_m] = wd;
      err_m = (wl != (ptr_m == 7));
      if (wl || ptr_m == 7) complete_m = 1'b1;
      ptr_m++;
      void'(wq.pop_front());
    end
    tick0_m = bnd0;
    tick2_m = bnd2;
    t++;
    if (t % 5 == 1) bl_m = int'(bright);
  endtask

  task automatic check_cycle();
    int r0, o0, r2;
    logic [7:0] er, ec, ir, ic, er2;
    r0  = (t / 5) % 8;
    o0  = t % 5;
    er  = (o0 >= 1) ? 8'(1 << r0) : 8'h00;
    ec  = (o0 >= 1 && (o0 - 1) < bl_m) ? front_m[r0] : 8'h00;
    ir  = ~er;
    ic  = ~ec;
    r2  = (t / 4) % 8;
    er2 = 8'(1 << r2);
    if (ft0 === 1'b1) ticks_obs++;
    chk("row0", 32'(row0), 32'(er));
    chk("col0", 32'(col0), 32'(ec));
    chk("scan_row0", 32'(sr0), 32'(r0));
    chk("tick0", 32'(ft0), 32'(tick0_m));
    chk("ready0", 32'(if0.wr_ready), 32'(!complete_m));
    chk("err0", 32'(if0.wr_err), 32'(err_m));
    chk("row1", 32'(row1), 32'(ir));
    chk("col1", 32'(col1), 32'(ic));
    chk("scan_row1", 32'(sr1), 32'(r0));
    chk("tick1", 32'(ft1), 32'(tick0_m));
    chk("err1", 32'(if1.wr_err), 32'(err_m));
    chk("row2", 32'(row2), 32'(er2));
    chk("col2", 32'(col2), 32'h00);
    chk("scan_row2", 32'(sr2), 32'(r2));
    chk("tick2", 32'(ft2), 32'(tick2_m));
  endtask

  task automatic drive_next();
    if (wq.size() > 0 && (!rand_gaps || $urandom_range(0, 3) != 0)) begin
      wv = 1'b1;
      wd = wq[0].d;
      wl = wq[0].l;
    end else begin
      wv = 1'b0;
      wd = 8'($urandom);
      wl = 1'($urandom_range(0, 1));
    end
    if (rand_bright && $urandom_range(0, 2) == 0) bright = 3'($urandom_range(0, 7));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_cycle();
    drive_next();
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic push_frame(input int nrows, input int last_at, input bit seq);
    wr_t w;
    for (int i = 0; i < nrows; i++) begin
      w.d = seq ? 8'(1 << i) : 8'($urandom);
      w.l = (i == last_at);
      wq.push_back(w);
    end
  endtask

  initial begin
    bright      = 3'd4;
    rand_gaps   = 1'b0;
    rand_bright = 1'b0;
    model_reset();
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset("reset");
    reset = 1'b1;

    // Idle scan with an all-zero front buffer: row timing and frame period.
    run(85);
    chk("tick_count_idle", 32'(ticks_obs), 32'd2);

    // Walking-one frame with wr_last on row 7.
    push_frame(8, 7, 1'b1);
    run(100);

    // Brightness: half, dark, full, then random mid-row changes.
    bright = 3'd2; run(40);
    bright = 3'd0; run(40);
    bright = 3'd7; run(40);
    rand_bright = 1'b1; run(80);
    rand_bright = 1'b0; bright = 3'd4;

    // Early wr_last on the third row, then eight rows with no wr_last.
    push_frame(3, 2, 1'b0);
    run(90);
    push_frame(8, -1, 1'b0);
    run(90);

    // Random frames with stalls and random brightness.
    rand_gaps   = 1'b1;
    rand_bright = 1'b1;
    for (int k = 0; k < 4; k++) begin
      push_frame(8, (k == 1) ? 4 : 7, 1'b0);
      run(85);
    end
    rand_gaps   = 1'b0;
    rand_bright = 1'b0;
    bright      = 3'd7;

    // Reset in the middle of a write burst.
    push_frame(8, 7, 1'b0);
    run(3);
    #2 reset = 1'b0;
    #1 chk_reset("midreset");
    model_reset();
    repeat (2) @(negedge clk);
    chk_reset("midreset_hold");
    reset = 1'b1;
    run(45);
    chk("tick_count_after_reset", 32'(ticks_obs), 32'd1);

    // A fresh frame after reset lands from row 0.
    push_frame(8, 7, 1'b0);
    run(90);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
